// File: rtl/maze_pkg.sv
// Shared types for the maze move engine: direction encoding, cell codes and FSM states.
package maze_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  localparam int unsigned CellOccupied  = 0;
  localparam int unsigned CellAvailable = 1;
  localparam int unsigned CellStart     = 2;
  localparam int unsigned CellEnd       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWait,
    StDone,
    StWon
  } state_e;

endpackage

// File: rtl/maze_bounds_check.sv
// Combinational candidate-cell computation; edges are tested before any arithmetic.
module maze_bounds_check
  import maze_pkg::*;
#(
  parameter int unsigned COLS = 24,
  parameter int unsigned ROWS = 24,
  parameter int unsigned X_W  = 5,
  parameter int unsigned Y_W  = 5
) (
  input  logic [X_W-1:0] pos_x_i,
  input  logic [Y_W-1:0] pos_y_i,
  input  dir_e           dir_i,
  output logic           in_bounds_o,
  output logic [X_W-1:0] cand_x_o,
  output logic [Y_W-1:0] cand_y_o
);

  always_comb begin
    in_bounds_o = 1'b1;
    cand_x_o    = pos_x_i;
    cand_y_o    = pos_y_i;
    unique case (dir_i)
      DirUp: begin
        if (pos_y_i == '0) in_bounds_o = 1'b0;
        else               cand_y_o    = pos_y_i - Y_W'(1);
      end
      DirDown: begin
        if (pos_y_i >= Y_W'(ROWS - 1)) in_bounds_o = 1'b0;
        else                           cand_y_o    = pos_y_i + Y_W'(1);
      end
      DirLeft: begin
        if (pos_x_i == '0) in_bounds_o = 1'b0;
        else               cand_x_o    = pos_x_i - X_W'(1);
      end
      DirRight: begin
        if (pos_x_i >= X_W'(COLS - 1)) in_bounds_o = 1'b0;
        else                           cand_x_o    = pos_x_i + X_W'(1);
      end
      default: in_bounds_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_move_engine.sv
// Accepts one direction request, bounds-checks it, reads the maze RAM and commits or rejects.
module maze_move_engine
  import maze_pkg::*;
#(
  parameter int unsigned COLS        = 24,
  parameter int unsigned ROWS        = 24,
  parameter int unsigned X_W         = 5,
  parameter int unsigned Y_W         = 5,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CELL_W      = 3,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned START_X     = 0,
  parameter int unsigned START_Y     = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dir_valid_i,
  input  logic [1:0]        dir_i,
  output logic              dir_ready_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [CELL_W-1:0] mem_rdata_i,
  output logic [X_W-1:0]    pos_x_o,
  output logic [Y_W-1:0]    pos_y_o,
  output logic              move_done_o,
  output logic              move_legal_o,
  output logic              game_over_o,
  output logic [CNT_W-1:0]  move_count_o
);

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [X_W-1:0]    pos_x_q, pos_x_d, cand_x_q, cand_x_d, bc_cand_x;
  logic [Y_W-1:0]    pos_y_q, pos_y_d, cand_y_q, cand_y_d, bc_cand_y;
  logic              in_bounds_q, in_bounds_d, bc_in_bounds;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              legal_q, legal_d;
  logic              game_over_q, game_over_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] cand_addr;

  maze_bounds_check #(
    .COLS(COLS),
    .ROWS(ROWS),
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_bounds (
    .pos_x_i    (pos_x_q),
    .pos_y_i    (pos_y_q),
    .dir_i      (dir_e'(dir_i)),
    .in_bounds_o(bc_in_bounds),
    .cand_x_o   (bc_cand_x),
    .cand_y_o   (bc_cand_y)
  );

  assign cand_addr = ADDR_W'(cand_y_q) * ADDR_W'(COLS) + ADDR_W'(cand_x_q);

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    in_bounds_d = in_bounds_q;
    lat_d       = lat_q;
    legal_d     = legal_q;
    game_over_d = game_over_q;
    count_d     = count_q;
    dir_ready_o = 1'b0;
    mem_rd_en_o = 1'b0;
    move_done_o = 1'b0;
    mem_addr_o  = '0;
    unique case (state_q)
      StIdle: begin
        dir_ready_o = 1'b1;
        if (dir_valid_i) begin
          cand_x_d    = bc_cand_x;
          cand_y_d    = bc_cand_y;
          in_bounds_d = bc_in_bounds;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (in_bounds_q) begin
          mem_rd_en_o = 1'b1;
          mem_addr_o  = cand_addr;
          lat_d       = LatW'(MEM_LATENCY - 1);
          state_d     = StWait;
        end else begin
          legal_d = 1'b0;
          state_d = StDone;
        end
      end
      StWait: begin
        mem_addr_o = cand_addr;
        if (lat_q == '0) begin
          // Last WAIT cycle: RAM data is valid now, commit at the edge entering DONE.
          state_d = StDone;
          legal_d = (mem_rdata_i != CELL_W'(CellOccupied));
          if (legal_d) begin
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (mem_rdata_i == CELL_W'(CellEnd)) game_over_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - LatW'(1);
        end
      end
      StDone: begin
        move_done_o = 1'b1;
        state_d     = game_over_q ? StWon : StIdle;
      end
      StWon: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      pos_x_q     <= X_W'(START_X);
      pos_y_q     <= Y_W'(START_Y);
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      in_bounds_q <= 1'b0;
      lat_q       <= '0;
      legal_q     <= 1'b0;
      game_over_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      in_bounds_q <= in_bounds_d;
      lat_q       <= lat_d;
      legal_q     <= legal_d;
      game_over_q <= game_over_d;
      count_q     <= count_d;
    end
  end

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign move_legal_o = legal_q;
  assign game_over_o  = game_over_q;
  assign move_count_o = count_q;

endmodule

// File: tb/tb_maze_move_engine.sv
// Directed bench: default engine (24x24, latency 2) and a 32x32 latency-4 engine from (5,5).
module tb_maze_move_engine;

  logic       clk, rst;
  logic       dv    [2];
  logic [1:0] dr    [2];
  logic       rdy   [2];
  logic       rden  [2];
  logic       done  [2];
  logic       legal [2];
  logic       go    [2];
  logic [9:0] addr  [2];
  logic [2:0] rdata [2];
  logic [4:0] px    [2];
  logic [4:0] py    [2];
  logic [15:0] cnt  [2];

  logic [2:0] mem_a [1024];
  logic [2:0] mem_b [1024];
  logic [2:0] pa [2];
  logic [2:0] pb [4];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  maze_move_engine u_dut_a (
    .clock       (clk),
    .reset       (rst),
    .dir_valid_i (dv[0]),
    .dir_i       (dr[0]),
    .dir_ready_o (rdy[0]),
    .mem_rd_en_o (rden[0]),
    .mem_addr_o  (addr[0]),
    .mem_rdata_i (rdata[0]),
    .pos_x_o     (px[0]),
    .pos_y_o     (py[0]),
    .move_done_o (done[0]),
    .move_legal_o(legal[0]),
    .game_over_o (go[0]),
    .move_count_o(cnt[0])
  );

  maze_move_engine #(
    .COLS(32), .ROWS(32), .X_W(5), .Y_W(5), .ADDR_W(10), .CELL_W(3),
    .MEM_LATENCY(4), .START_X(5), .START_Y(5), .CNT_W(16)
  ) u_dut_b (
    .clock       (clk),
    .reset       (rst),
    .dir_valid_i (dv[1]),
    .dir_i       (dr[1]),
    .dir_ready_o (rdy[1]),
    .mem_rd_en_o (rden[1]),
    .mem_addr_o  (addr[1]),
    .mem_rdata_i (rdata[1]),
    .pos_x_o     (px[1]),
    .pos_y_o     (py[1]),
    .move_done_o (done[1]),
    .move_legal_o(legal[1]),
    .game_over_o (go[1]),
    .move_count_o(cnt[1])
  );

  // RAM models; idle slots carry OCCUPIED so mistimed sampling reads as a wall.
  always @(posedge clk) begin
    pa[0] <= rden[0] ? mem_a[addr[0]] : 3'd0;
    pa[1] <= pa[0];
    pb[0] <= rden[1] ? mem_b[addr[1]] : 3'd0;
    for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
  end
  assign rdata[0] = pa[1];
  assign rdata[1] = pb[3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_move(input int s, input logic [1:0] d, input int e_lat, input int e_rd,
                         input int e_addr, input logic e_legal, input int ex, input int ey,
                         input int ecnt, input string tag);
    int k;
    int rdn;
    logic [9:0] seen;
    @(negedge clk);
    check_eq({tag, ".ready"}, 32'(rdy[s]), 1);
    dv[s] = 1'b1;
    dr[s] = d;
    @(posedge clk);
    k = 0; rdn = 0; seen = '0;
    do begin
      @(negedge clk);
      dv[s] = 1'b0;
      k++;
      if (rden[s]) begin
        rdn++;
        seen = addr[s];
      end
    end while (!done[s] && k < 20);
    check_eq({tag, ".lat"}, k, e_lat);
    check_eq({tag, ".rd"}, rdn, e_rd);
    if (e_addr >= 0) check_eq({tag, ".addr"}, 32'(seen), e_addr);
    check_eq({tag, ".legal"}, 32'(legal[s]), 32'(e_legal));
    check_eq({tag, ".x"}, 32'(px[s]), ex);
    check_eq({tag, ".y"}, 32'(py[s]), ey);
    check_eq({tag, ".cnt"}, 32'(cnt[s]), ecnt);
  endtask

  initial begin
    int nd;
    int nr;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 3'd1;
      mem_b[i] = 3'd1;
    end
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0;
      dr[i] = 2'b00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst.x", 32'(px[0]), 0);
    check_eq("rst.y", 32'(py[0]), 0);
    check_eq("rst.cnt", 32'(cnt[0]), 0);
    check_eq("rst.legal", 32'(legal[0]), 0);
    check_eq("rst.go", 32'(go[0]), 0);
    check_eq("rst.done", 32'(done[0]), 0);
    check_eq("rst.rden", 32'(rden[0]), 0);
    check_eq("rst.addr", 32'(addr[0]), 0);
    check_eq("rst.ready", 32'(rdy[0]), 1);
    check_eq("rst.bx", 32'(px[1]), 5);
    check_eq("rst.by", 32'(py[1]), 5);

    do_move(0, 2'b11, 4, 1, 1, 1'b1, 1, 0, 1, "a_right");
    do_move(0, 2'b10, 4, 1, 0, 1'b1, 0, 0, 2, "a_left_back");
    do_move(0, 2'b00, 2, 0, -1, 1'b0, 0, 0, 2, "a_up_oob");
    do_move(0, 2'b10, 2, 0, -1, 1'b0, 0, 0, 2, "a_left_oob");
    mem_a[1] = 3'd0;
    do_move(0, 2'b11, 4, 1, 1, 1'b0, 0, 0, 2, "a_wall");
    mem_a[24] = 3'd3;
    do_move(0, 2'b01, 4, 1, 24, 1'b1, 0, 1, 3, "a_end");
    check_eq("a_end.go", 32'(go[0]), 1);
    @(negedge clk);
    check_eq("won.ready", 32'(rdy[0]), 0);
    dv[0] = 1'b1;
    dr[0] = 2'b11;
    nd = 0; nr = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) nd++;
      if (rden[0]) nr++;
    end
    dv[0] = 1'b0;
    check_eq("won.done", nd, 0);
    check_eq("won.rden", nr, 0);
    check_eq("won.x", 32'(px[0]), 0);
    check_eq("won.y", 32'(py[0]), 1);
    check_eq("won.go", 32'(go[0]), 1);

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst2.go", 32'(go[0]), 0);
    check_eq("rst2.y", 32'(py[0]), 0);
    check_eq("rst2.ready", 32'(rdy[0]), 1);

    do_move(1, 2'b01, 6, 1, 197, 1'b1, 5, 6, 1, "b_down");
    do_move(1, 2'b00, 6, 1, 165, 1'b1, 5, 5, 2, "b_up");
    for (int i = 0; i < 26; i++) do_move(1, 2'b11, 6, 1, -1, 1'b1, 6 + i, 5, 3 + i, "b_walk");
    do_move(1, 2'b11, 2, 0, -1, 1'b0, 31, 5, 28, "b_right_oob");

    mem_a[1] = 3'd1;
    do_move(0, 2'b11, 4, 1, 1, 1'b1, 1, 0, 1, "c_pre");
    @(negedge clk);
    dv[0] = 1'b1;
    dr[0] = 2'b11;
    @(posedge clk);
    @(negedge clk);
    dv[0] = 1'b0;
    @(negedge clk);
    check_eq("c_inwait.addr", 32'(addr[0]), 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("c_rst.x", 32'(px[0]), 0);
    check_eq("c_rst.y", 32'(py[0]), 0);
    check_eq("c_rst.cnt", 32'(cnt[0]), 0);
    check_eq("c_rst.legal", 32'(legal[0]), 0);
    check_eq("c_rst.addr", 32'(addr[0]), 0);
    check_eq("c_rst.ready", 32'(rdy[0]), 1);
    nd = 0;
    repeat (6) begin
      if (done[0]) nd++;
      @(negedge clk);
    end
    check_eq("c_late.done", nd, 0);
    check_eq("c_late.x", 32'(px[0]), 0);
    check_eq("c_late.cnt", 32'(cnt[0]), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
